register_bank: RTL and testbench
================================

// Module: register_bank
// PURPOSE
//   Parametrised bank of NUM_REGS general-purpose registers, WIDTH bits each, sharing one
//   3-bit FunSel operation code with a per-register enable mask. Two combinational read
//   ports (OutA/OutB) feed the ALU operand muxes. Sticky per-register wrap flags record
//   increment/decrement overflow. Replaces discrete 16-bit registers in the datapath.
// PARAMETERS
//   WIDTH     16  register width in bits; must be even and >= 8; HALF = WIDTH/2
//   NUM_REGS  4   number of registers; >= 2; SEL_W = $clog2(NUM_REGS) (localparam)
// PORTS
//   Clock     in   1         rising-edge clock, only clock in the block
//   Reset     in   1         synchronous, active-high reset
//   I         in   WIDTH     write data
//   RegSel    in   NUM_REGS  per-register enable mask; bit k=1 applies FunSel to reg k
//   FunSel    in   3         operation code, see BEHAVIOUR
//   OutASel   in   SEL_W     read port A register index
//   OutBSel   in   SEL_W     read port B register index
//   OutA      out  WIDTH     contents of register OutASel
//   OutB      out  WIDTH     contents of register OutBSel
//   Wrap      out  NUM_REGS  sticky wrap flag per register
// BEHAVIOUR
//   - One clock, synchronous, active-high reset. Reset at an edge: all registers = 0,
//     Wrap = 0; overrides RegSel/FunSel and all other inputs that edge.
//   - All enabled registers (RegSel[k]=1) update at the same edge with the same op;
//     disabled registers hold value and Wrap bit. RegSel=0 -> no state change.
//   - FunSel (Q = reg k, L = I[HALF-1:0]):
//       000 Q <= Q-1 (mod 2^WIDTH)       001 Q <= Q+1 (mod 2^WIDTH)
//       010 Q <= I                       011 Q <= 0, Wrap[k] <= 0
//       100 Q <= {HALF zeros, L}         101 Q[HALF-1:0] <= L, upper half held
//       110 Q[WIDTH-1:HALF] <= L, lower half held
//       111 Q <= {HALF copies of L[HALF-1], L}
//   - Wrap[k] set on 000 when Q==0 (result all-ones) or on 001 when Q==all-ones
//     (result 0). Stays set until FunSel=011 on reg k or Reset. Other ops leave it.
//   - Reads combinational, zero latency: OutA/OutB show pre-edge contents; a write is
//     visible on the outputs the cycle after its edge (no write-through bypass).
//   - OutASel==OutBSel allowed; both ports show the same register.
//   - Index >= NUM_REGS (non-power-of-2 counts): output reads 0.
//   - FunSel values outside 000-111 (X/Z) are don't-care in synthesis; sim holds Q.
// CONFIGURATION
//   REGBANK_SHADOW_EN defined: adds inputs Save (1), Restore (1) and a shadow copy of
//     every register and Wrap bit.
//     - Save=1: shadow <= pre-edge register/Wrap values at that edge (RegSel ops that
//       same edge still apply to the live bank; shadow gets old values).
//     - Restore=1: all registers and Wrap <= shadow next edge; overrides RegSel/FunSel.
//     - Save & Restore same edge: live <= old shadow, shadow <= old live (swap).
//     - Reset clears shadow too; priority Reset > Restore > RegSel/FunSel.
//   Not defined: Save/Restore ports and shadow storage do not exist; bank behaves as
//     above with no extra latency or area.
// TESTING
//   1. Reset=1 one edge -> all OutA/OutB reads 0, Wrap=0 for every register.
//   2. RegSel=0001, FunSel=010, I=0xBEEF; next cycle OutASel=0 -> OutA=0xBEEF, others 0.
//   3. Reg1=0x12FF, FunSel=111 I=0x0080 -> 0xFF80; then 110 I=0x0034 -> 0x3480;
//      then 101 I=0x00AB -> 0x34AB; then 100 I=0x00CD -> 0x00CD.
//   4. Reg2=0xFFFF, FunSel=001 -> 0x0000, Wrap[2]=1; FunSel=010 I=5 -> Wrap[2] stays 1;
//      FunSel=011 -> Wrap[2]=0; then FunSel=000 on 0 -> 0xFFFF, Wrap[2]=1.
//   5. RegSel=1111 FunSel=001 with mid-op Reset=1 same edge -> all regs 0, Wrap 0;
//      OutA/OutB during that cycle still show pre-edge values.
//   6. REGBANK_SHADOW_EN: load reg0=0x1111, Save; load reg0=0x2222; Restore -> 0x1111;
//      Save&Restore same edge with reg0=0x3333, shadow=0x1111 -> reg0=0x1111, shadow=0x3333.

Source files
------------

// File: rtl/register_bank.sv
// Register bank: NUM_REGS x WIDTH registers with a shared FunSel op, per-register enable
// mask, two combinational read ports and sticky wrap flags. Optional shadow copy: REGBANK_SHADOW_EN.
module register_bank #(
  parameter int  WIDTH    = 16,
  parameter int  NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [2:0]          FunSel,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
`ifdef REGBANK_SHADOW_EN
  input  logic                Save,
  input  logic                Restore,
`endif
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] Wrap
);

  localparam int HALF = WIDTH / 2;
  localparam logic [SEL_W:0] NUM_REGS_IDX = (SEL_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    FS_DEC     = 3'b000,
    FS_INC     = 3'b001,
    FS_LOAD    = 3'b010,
    FS_CLR     = 3'b011,
    FS_LOW_ZX  = 3'b100,
    FS_LOW     = 3'b101,
    FS_HIGH    = 3'b110,
    FS_LOW_SX  = 3'b111
  } fun_sel_e;

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wrap_q;
  logic [NUM_REGS-1:0] wrap_d;
  logic [HALF-1:0]     low_i;

  assign low_i = I[HALF-1:0];

`ifdef REGBANK_SHADOW_EN
  logic [WIDTH-1:0]    shadow_q [NUM_REGS];
  logic [WIDTH-1:0]    shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0] shadow_wrap_q;
  logic [NUM_REGS-1:0] shadow_wrap_d;

  // Save captures the pre-edge live bank, so a simultaneous Restore swaps the two copies.
  always_comb begin
    shadow_d      = shadow_q;
    shadow_wrap_d = shadow_wrap_q;
    if (Save) begin
      shadow_d      = regs_q;
      shadow_wrap_d = wrap_q;
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
      regs_d[k] = regs_q[k];
      wrap_d[k] = wrap_q[k];
      if (RegSel[k]) begin
        case (FunSel)
          FS_DEC: begin
            regs_d[k] = regs_q[k] - WIDTH'(1);
            if (regs_q[k] == '0) wrap_d[k] = 1'b1;
          end
          FS_INC: begin
            regs_d[k] = regs_q[k] + WIDTH'(1);
            if (regs_q[k] == '1) wrap_d[k] = 1'b1;
          end
          FS_LOAD:   regs_d[k] = I;
          FS_CLR: begin
            regs_d[k] = '0;
            wrap_d[k] = 1'b0;
          end
          FS_LOW_ZX: regs_d[k] = {{HALF{1'b0}}, low_i};
          FS_LOW:    regs_d[k][HALF-1:0] = low_i;
          FS_HIGH:   regs_d[k][WIDTH-1:HALF] = low_i;
          FS_LOW_SX: regs_d[k] = {{HALF{low_i[HALF-1]}}, low_i};
          default: ;
        endcase
      end
    end
`ifdef REGBANK_SHADOW_EN
    if (Restore) begin
      regs_d = shadow_q;
      wrap_d = shadow_wrap_q;
    end
`endif
  end

  always_ff @(posedge Clock) begin
    // NOTE: the whole array is reset because reads must return 0 straight out of reset.
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wrap_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of ordering.
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef REGBANK_SHADOW_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) shadow_q[k] <= '0;
      shadow_wrap_q <= '0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_wrap_q <= shadow_wrap_d;
    end
  end
`endif

  // Indices past the last register (non-power-of-2 banks) read as zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    if ({1'b0, OutASel} < NUM_REGS_IDX) OutA = regs_q[OutASel];
    if ({1'b0, OutBSel} < NUM_REGS_IDX) OutB = regs_q[OutBSel];
  end

  assign Wrap = wrap_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus randomized ops scored
// against an integer-arithmetic model of the bank (and shadow when REGBANK_SHADOW_EN).
module tb_register_bank;

  localparam int WIDTH = 16;
  localparam int NREGS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] i_data;
  logic [3:0]  reg_sel;
  logic [2:0]  fun_sel;
  logic [1:0]  a_sel, b_sel;
  logic        save, restore;
  logic [15:0] out_a, out_b;
  logic [3:0]  wrap;

  int total = 0;
  int bad   = 0;

  // Reference state: plain integers, one entry per register.
  int m_regs [NREGS];
  int m_wrap [NREGS];
  int s_regs [NREGS];
  int s_wrap [NREGS];

  always #5 clock = ~clock;

  register_bank #(.WIDTH(WIDTH), .NUM_REGS(NREGS)) dut (
    .Clock   (clock),
    .Reset   (reset),
    .I       (i_data),
    .RegSel  (reg_sel),
    .FunSel  (fun_sel),
    .OutASel (a_sel),
    .OutBSel (b_sel),
`ifdef REGBANK_SHADOW_EN
    .Save    (save),
    .Restore (restore),
`endif
    .OutA    (out_a),
    .OutB    (out_b),
    .Wrap    (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int op_result(input int q, input int fs, input int d);
    int lo;
    lo = d % 256;
    case (fs)
      0: return (q == 0) ? 65535 : q - 1;
      1: return (q == 65535) ? 0 : q + 1;
      2: return d;
      3: return 0;
      4: return lo;
      5: return (q / 256) * 256 + lo;
      6: return lo * 256 + (q % 256);
      default: return (lo >= 128) ? 65280 + lo : lo;
    endcase
  endfunction

  function automatic logic [3:0] model_wrap_vec();
    logic [3:0] v;
    for (int k = 0; k < NREGS; k++) v[k] = (m_wrap[k] != 0);
    return v;
  endfunction

  // Drive inputs, update the model from pre-edge state, then move 1ns past the edge.
  task automatic apply(input logic rst, input logic [3:0] rs, input logic [2:0] fs,
                       input logic [15:0] d, input logic sv, input logic rsto);
    int new_regs [NREGS];
    int new_wrap [NREGS];
    reset   = rst;
    reg_sel = rs;
    fun_sel = fs;
    i_data  = d;
    save    = sv;
    restore = rsto;
    for (int k = 0; k < NREGS; k++) begin
      new_regs[k] = m_regs[k];
      new_wrap[k] = m_wrap[k];
      if (rs[k]) begin
        new_regs[k] = op_result(m_regs[k], int'(fs), int'(d));
        if (fs == 3'd0 && m_regs[k] == 0)     new_wrap[k] = 1;
        if (fs == 3'd1 && m_regs[k] == 65535) new_wrap[k] = 1;
        if (fs == 3'd3)                        new_wrap[k] = 0;
      end
    end
`ifdef REGBANK_SHADOW_EN
    if (rsto) begin
      for (int k = 0; k < NREGS; k++) begin
        new_regs[k] = s_regs[k];
        new_wrap[k] = s_wrap[k];
      end
    end
    if (sv) begin
      for (int k = 0; k < NREGS; k++) begin
        s_regs[k] = m_regs[k];
        s_wrap[k] = m_wrap[k];
      end
    end
`endif
    for (int k = 0; k < NREGS; k++) begin
      m_regs[k] = rst ? 0 : new_regs[k];
      m_wrap[k] = rst ? 0 : new_wrap[k];
      if (rst) begin
        s_regs[k] = 0;
        s_wrap[k] = 0;
      end
    end
    @(posedge clock);
    #1;
    reset   = 1'b0;
    reg_sel = '0;
    save    = 1'b0;
    restore = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < NREGS; r++) begin
      a_sel = 2'(r);
      b_sel = 2'(NREGS - 1 - r);
      #1;
      check($sformatf("%s.a%0d", tag, r), 32'(out_a), 32'(m_regs[r]));
      check($sformatf("%s.b%0d", tag, NREGS - 1 - r), 32'(out_b), 32'(m_regs[NREGS - 1 - r]));
    end
    check({tag, ".wrap"}, 32'(wrap), 32'(model_wrap_vec()));
  endtask

  initial begin
    for (int k = 0; k < NREGS; k++) begin
      m_regs[k] = 0; m_wrap[k] = 0; s_regs[k] = 0; s_wrap[k] = 0;
    end
    reset = 1'b1; reg_sel = '0; fun_sel = '0; i_data = '0;
    a_sel = '0; b_sel = '0; save = 1'b0; restore = 1'b0;
    #2;

    // Reset clears everything.
    apply(1'b1, 4'hF, 3'd2, 16'hAAAA, 1'b0, 1'b0);
    check_all("reset");

    // Full-word load into reg0 only.
    apply(1'b0, 4'b0001, 3'd2, 16'hBEEF, 1'b0, 1'b0);
    check_all("load0");
    check("load0.lit", 32'(dut.OutA), 32'h0000_0000 | 32'(m_regs[3]));
    a_sel = 2'd0; #1;
    check("load0.beef", 32'(out_a), 32'h0000_BEEF);

    // Half-word ops on reg1.
    apply(1'b0, 4'b0010, 3'd2, 16'h12FF, 1'b0, 1'b0);
    apply(1'b0, 4'b0010, 3'd7, 16'h0080, 1'b0, 1'b0);
    a_sel = 2'd1; #1; check("sx", 32'(out_a), 32'h0000_FF80);
    apply(1'b0, 4'b0010, 3'd6, 16'h0034, 1'b0, 1'b0);
    a_sel = 2'd1; #1; check("hi", 32'(out_a), 32'h0000_3480);
    apply(1'b0, 4'b0010, 3'd5, 16'h00AB, 1'b0, 1'b0);
    a_sel = 2'd1; #1; check("lo", 32'(out_a), 32'h0000_34AB);
    apply(1'b0, 4'b0010, 3'd4, 16'h00CD, 1'b0, 1'b0);
    a_sel = 2'd1; #1; check("zx", 32'(out_a), 32'h0000_00CD);
    check_all("half");

    // Wrap flag behaviour on reg2.
    apply(1'b0, 4'b0100, 3'd2, 16'hFFFF, 1'b0, 1'b0);
    apply(1'b0, 4'b0100, 3'd1, 16'h0000, 1'b0, 1'b0);
    b_sel = 2'd2; #1;
    check("inc_wrap.val", 32'(out_b), 32'h0);
    check("inc_wrap.flag", 32'(wrap[2]), 32'h1);
    apply(1'b0, 4'b0100, 3'd2, 16'h0005, 1'b0, 1'b0);
    check("wrap_sticky", 32'(wrap[2]), 32'h1);
    apply(1'b0, 4'b0100, 3'd3, 16'h0000, 1'b0, 1'b0);
    check("wrap_clr", 32'(wrap[2]), 32'h0);
    apply(1'b0, 4'b0100, 3'd0, 16'h0000, 1'b0, 1'b0);
    b_sel = 2'd2; #1;
    check("dec_wrap.val", 32'(out_b), 32'hFFFF);
    check("dec_wrap.flag", 32'(wrap[2]), 32'h1);
    check_all("wrapseq");

    // RegSel=0 changes nothing.
    apply(1'b0, 4'b0000, 3'd3, 16'h1234, 1'b0, 1'b0);
    check_all("nosel");

    // Reset wins over an all-register increment; reads before the edge show old values.
    reset = 1'b1; reg_sel = 4'hF; fun_sel = 3'd1; a_sel = 2'd2; b_sel = 2'd0; #1;
    check("prereset.a", 32'(out_a), 32'(m_regs[2]));
    check("prereset.b", 32'(out_b), 32'(m_regs[0]));
    apply(1'b1, 4'hF, 3'd1, 16'h0000, 1'b0, 1'b0);
    check_all("midreset");

`ifdef REGBANK_SHADOW_EN
    apply(1'b0, 4'b0001, 3'd2, 16'h1111, 1'b0, 1'b0);
    apply(1'b0, 4'b0000, 3'd0, 16'h0000, 1'b1, 1'b0);
    apply(1'b0, 4'b0001, 3'd2, 16'h2222, 1'b0, 1'b0);
    a_sel = 2'd0; #1; check("sh.live", 32'(out_a), 32'h2222);
    apply(1'b0, 4'b0000, 3'd0, 16'h0000, 1'b0, 1'b1);
    a_sel = 2'd0; #1; check("sh.restore", 32'(out_a), 32'h1111);
    apply(1'b0, 4'b0001, 3'd2, 16'h3333, 1'b0, 1'b0);
    apply(1'b0, 4'b0001, 3'd1, 16'h0000, 1'b1, 1'b1);
    a_sel = 2'd0; #1; check("sh.swap_live", 32'(out_a), 32'h1111);
    apply(1'b0, 4'b0000, 3'd0, 16'h0000, 1'b0, 1'b1);
    a_sel = 2'd0; #1; check("sh.swap_shadow", 32'(out_a), 32'h3333);
    check_all("shadow");
`endif

    // Randomized ops, with occasional reset (and save/restore when built in).
    for (int n = 0; n < 250; n++) begin
      logic rst_r, sv_r, rs_r;
      rst_r = ($urandom_range(0, 31) == 0);
`ifdef REGBANK_SHADOW_EN
      sv_r  = ($urandom_range(0, 7) == 0);
      rs_r  = ($urandom_range(0, 7) == 0);
`else
      sv_r  = 1'b0;
      rs_r  = 1'b0;
`endif
      // Bias toward boundary values so wrap paths get exercised.
      case ($urandom_range(0, 3))
        0: i_data = 16'hFFFF;
        1: i_data = 16'h0000;
        default: i_data = 16'($urandom);
      endcase
      apply(rst_r, 4'($urandom), 3'($urandom), i_data, sv_r, rs_r);
      check_all($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
